// File: rtl/cpuc_grid_seq.sv
// CPUC sequenced transport grid: every destination register picks its source through a
// mux, driven by a small program memory with run/halt control, conditional jumps and a watchdog.

module cpuc_grid_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int KIND       = 0,   // 0 adder, 1 max, 2 equality
    parameter int SIGNED_CMP = 1
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);
    logic gt;

    always_comb begin
        if (SIGNED_CMP != 0) gt = $signed(a) > $signed(b);
        else                 gt = a > b;
        if (KIND == 0)      y = a + b;
        else if (KIND == 1) y = gt ? a : b;
        else                y = (a == b) ? '1 : '0;
    end
endmodule

module cpuc_grid_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int NUM_ADDERS = 2,
    parameter int NUM_CMP    = 2,
    parameter int NUM_EQUAL  = 2,
    parameter int SIGNED_CMP = 1,
    parameter int PROG_DEPTH = 16,
    parameter int MAX_CYCLES = 1024,
    localparam int NUM_UNITS = NUM_ADDERS + NUM_CMP + NUM_EQUAL,
    localparam int NUM_SRC   = NUM_REGS + NUM_UNITS + 2,
    localparam int SRC_W     = $clog2(NUM_SRC),
    localparam int OP_W      = $clog2(NUM_REGS + 1),
    localparam int PC_W      = $clog2(PROG_DEPTH),
    localparam int CNT_W     = $clog2(MAX_CYCLES + 1),
    localparam int INST_W    = DATA_WIDTH + 1 + OP_W + SRC_W + NUM_REGS*SRC_W + 2*OP_W*NUM_UNITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           prog_wr_valid,
    output logic                           prog_wr_ready,
    input  logic [PC_W-1:0]                prog_wr_addr,
    input  logic [INST_W-1:0]              prog_wr_data,
    output logic                           busy,
    output logic                           halted,
    output logic                           timeout,
    output logic [PC_W-1:0]                pc_out,
    output logic [CNT_W-1:0]               cycle_count,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_outputs
);
    localparam int COND_LSB  = DATA_WIDTH + 1;
    localparam int PCSRC_LSB = COND_LSB + OP_W;
    localparam int DEST_LSB  = PCSRC_LSB + SRC_W;
    localparam int OPND_LSB  = DEST_LSB + NUM_REGS*SRC_W;
    localparam int SRC_N     = 2**SRC_W;
    localparam int OP_N      = 2**OP_W;

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
    state_t state, state_d;

    logic [INST_W-1:0]                    prog_mem [PROG_DEPTH];
    logic [INST_W-1:0]                    inst;
    logic [PC_W-1:0]                      pc, pc_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs, regs_d;
    logic [NUM_REGS-1:0][SRC_W-1:0]       dest;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] unit_out;
    logic [DATA_WIDTH-1:0]                opnd [OP_N];
    logic [DATA_WIDTH-1:0]                srcs [SRC_N];
    logic [DATA_WIDTH-1:0]                imm;
    logic [OP_W-1:0]                      cond;
    logic [SRC_W-1:0]                     pcsrc;
    logic [CNT_W-1:0]                     cnt, cnt_inc;
    logic                                 halt, cond_ok, wdog, load, exec, to;

    assign prog_wr_ready = (state != RUN);

    always_ff @(posedge clk)
        if (prog_wr_valid && prog_wr_ready) prog_mem[prog_wr_addr] <= prog_wr_data;

    assign inst  = prog_mem[pc];
    assign imm   = inst[DATA_WIDTH-1:0];
    assign halt  = inst[DATA_WIDTH];
    assign cond  = inst[COND_LSB +: OP_W];
    assign pcsrc = inst[PCSRC_LSB +: SRC_W];
    assign dest  = inst[DEST_LSB +: NUM_REGS*SRC_W];

    // Operand codes past IMM read as zero, so the table is padded to a full power of two.
    always_comb begin
        for (int i = 0; i < OP_N; i++) opnd[i] = '0;
        for (int i = 0; i < NUM_REGS; i++) opnd[i] = regs[i];
        opnd[NUM_REGS] = imm;
    end

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        localparam int KIND = (u < NUM_ADDERS) ? 0 : (u < NUM_ADDERS + NUM_CMP) ? 1 : 2;
        cpuc_grid_unit #(
            .DATA_WIDTH(DATA_WIDTH),
            .KIND      (KIND),
            .SIGNED_CMP(SIGNED_CMP)
        ) u_unit (
            .a(opnd[inst[OPND_LSB + 2*OP_W*u +: OP_W]]),
            .b(opnd[inst[OPND_LSB + 2*OP_W*u + OP_W +: OP_W]]),
            .y(unit_out[u])
        );
    end

    always_comb begin
        for (int i = 0; i < SRC_N; i++) srcs[i] = '0;
        for (int i = 0; i < NUM_REGS; i++) srcs[1 + i] = regs[i];
        for (int u = 0; u < NUM_UNITS; u++) srcs[1 + NUM_REGS + u] = unit_out[u];
        srcs[NUM_SRC - 1] = imm;
    end

    always_comb begin
        regs_d = regs;
        for (int i = 0; i < NUM_REGS; i++)
            if (dest[i] != '0 && int'(dest[i]) < NUM_SRC) regs_d[i] = srcs[dest[i]];
    end

    // Condition k tests register k-1 before this instruction's writes land.
    always_comb begin
        cond_ok = (cond == '0);
        for (int k = 1; k <= NUM_REGS; k++)
            if (int'(cond) == k) cond_ok = (regs[k-1] != '0);
    end

    assign pc_d    = (pcsrc != '0 && cond_ok) ? srcs[pcsrc][PC_W-1:0] : pc + PC_W'(1);
    assign cnt_inc = cnt + CNT_W'(1);
    assign wdog    = (cnt_inc == CNT_W'(MAX_CYCLES));

    always_comb begin
        state_d = state;
        load    = 1'b0;
        exec    = 1'b0;
        case (state)
            IDLE, HALTED: if (start) begin
                state_d = RUN;
                load    = 1'b1;
            end
            RUN: begin
                exec = 1'b1;
                if (halt || wdog) state_d = HALTED;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc   <= '0;
            regs <= '0;
            cnt  <= '0;
            to   <= 1'b0;
        end else if (load) begin
            pc   <= '0;
            regs <= '0;
            cnt  <= '0;
            to   <= 1'b0;
        end else if (exec) begin
            regs <= regs_d;
            cnt  <= cnt_inc;
            if (!halt) pc <= pc_d;
            // A HALT landing on the watchdog limit is a clean halt.
            if (!halt && wdog) to <= 1'b1;
        end
    end

    assign busy        = (state == RUN);
    assign halted      = (state == HALTED);
    assign timeout     = to;
    assign pc_out      = pc;
    assign cycle_count = cnt;
    assign reg_outputs = regs;
endmodule

// File: tb/tb_cpuc_grid_seq.sv
// Two grid instances (signed max / 8-cycle watchdog, unsigned max / 16-cycle watchdog) fed
// the same stimulus; each run's outcome is predicted by an instruction-level model.

module tb_cpuc_grid_seq;
    localparam int IW = 121;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, wr_valid = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [IW-1:0] wr_data = '0;
    logic [1:0] ready_v, busy_v, halted_v, to_v;
    logic [1:0][3:0]   pc_v;
    logic [1:0][31:0]  cc_v;
    logic [1:0][255:0] regs_v;

    int checks = 0, failures = 0;
    logic [IW-1:0] img [16];

    typedef struct packed {
        logic [255:0] regs;
        logic [3:0]   pc;
        logic [31:0]  cnt;
        logic         to;
    } exp_t;
    exp_t q0[$], q1[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int MC = (g == 0) ? 8 : 16;
        logic [$clog2(MC+1)-1:0] cc;
        cpuc_grid_seq #(.SIGNED_CMP(g == 0 ? 1 : 0), .MAX_CYCLES(MC)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start),
            .prog_wr_valid(wr_valid),
            .prog_wr_ready(ready_v[g]),
            .prog_wr_addr (wr_addr),
            .prog_wr_data (wr_data),
            .busy         (busy_v[g]),
            .halted       (halted_v[g]),
            .timeout      (to_v[g]),
            .pc_out       (pc_v[g]),
            .cycle_count  (cc),
            .reg_outputs  (regs_v[g])
        );
        assign cc_v[g] = 32'(cc);
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int g, input int i);
        return regs_v[g][32*i +: 32];
    endfunction

    function automatic logic [31:0] opsel(input logic [7:0][31:0] r, input logic [31:0] imm, input int k);
        if (k < 8) return r[k[2:0]];
        if (k == 8) return imm;
        return 32'h0;
    endfunction

    // Executes the program image from pc 0 with cleared registers.
    function automatic exp_t model(input bit sgn, input int maxc);
        logic [7:0][31:0] r = '0, nr;
        logic [31:0] s [16];
        logic [31:0] a, b, imm;
        logic [IW-1:0] w;
        int pc = 0, n = 0, cnd, ps, d;
        bit taken;
        exp_t e = '0;
        for (int step = 0; step < maxc; step++) begin
            w   = img[pc];
            imm = w[31:0];
            cnd = int'(w[36:33]);
            ps  = int'(w[40:37]);
            s[0] = 32'h0;
            for (int i = 0; i < 8; i++) s[1+i] = r[i];
            for (int u = 0; u < 6; u++) begin
                a = opsel(r, imm, int'(w[73+8*u +: 4]));
                b = opsel(r, imm, int'(w[77+8*u +: 4]));
                if (u < 2)      s[9+u] = a + b;
                else if (u < 4) s[9+u] = (sgn ? ($signed(a) > $signed(b)) : (a > b)) ? a : b;
                else            s[9+u] = (a == b) ? 32'hFFFF_FFFF : 32'h0;
            end
            s[15] = imm;
            taken = 0;
            if (ps != 0) begin
                if (cnd == 0) taken = 1;
                else if (cnd <= 8) taken = (r[cnd-1] != 0);
            end
            for (int i = 0; i < 8; i++) begin
                d = int'(w[41+4*i +: 4]);
                nr[i] = (d == 0) ? r[i] : s[d];
            end
            r = nr;
            n++;
            if (w[32]) break;
            pc = taken ? int'(s[ps][3:0]) : (pc + 1) % 16;
            if (n == maxc) e.to = 1'b1;
        end
        e.regs = r;
        e.pc   = pc[3:0];
        e.cnt  = n;
        return e;
    endfunction

    function automatic logic [IW-1:0] ins(input logic [31:0] imm, input bit halt, input int cond, input int pcsrc);
        logic [IW-1:0] w = '0;
        w[31:0]  = imm;
        w[32]    = halt;
        w[36:33] = cond[3:0];
        w[40:37] = pcsrc[3:0];
        return w;
    endfunction

    function automatic logic [IW-1:0] dst(input logic [IW-1:0] w, input int r, input int s);
        w[41+4*r +: 4] = s[3:0];
        return w;
    endfunction

    function automatic logic [IW-1:0] opr(input logic [IW-1:0] w, input int u, input int a, input int b);
        w[73+8*u +: 4] = a[3:0];
        w[77+8*u +: 4] = b[3:0];
        return w;
    endfunction

    task automatic wr(input int addr, input logic [IW-1:0] data);
        wr_valid = 1'b1;
        wr_addr  = addr[3:0];
        wr_data  = data;
        img[addr] = data;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic expect_run();
        q0.push_back(model(1'b1, 8));
        q1.push_back(model(1'b0, 16));
    endtask

    task automatic go();
        expect_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (halted_v != 2'b11 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (halted_v != 2'b11) begin
            checks++;
            failures++;
            $display("FAIL run_done: halted=%b after %0d cycles", halted_v, n);
            q0.delete();
            q1.delete();
        end
        @(posedge clk); #1;
    endtask

    // Monitor: on each rising halted, pop the prediction and compare final state.
    initial begin
        int   bc [2];
        logic hd [2];
        exp_t e;
        bc = '{0, 0};
        hd = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (rst) begin
                    bc[g] = 0;
                    hd[g] = 1'b0;
                end else begin
                    if (busy_v[g]) bc[g]++;
                    if (halted_v[g] && !hd[g]) begin
                        if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
                            checks++;
                            failures++;
                            $display("FAIL dut%0d unexpected halt", g);
                        end else begin
                            if (g == 0) e = q0.pop_front();
                            else        e = q1.pop_front();
                            chk($sformatf("dut%0d regs", g), regs_v[g], e.regs);
                            chk($sformatf("dut%0d pc", g), 256'(pc_v[g]), 256'(e.pc));
                            chk($sformatf("dut%0d cycle_count", g), 256'(cc_v[g]), 256'(e.cnt));
                            chk($sformatf("dut%0d timeout", g), 256'(to_v[g]), 256'(e.to));
                            chk($sformatf("dut%0d busy_cycles", g), 256'(bc[g]), 256'(e.cnt));
                        end
                        bc[g] = 0;
                    end
                    hd[g] = halted_v[g];
                end
            end
        end
    end

    initial begin
        logic [IW-1:0] w;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst dut%0d busy", g), 256'(busy_v[g]), 256'(0));
            chk($sformatf("rst dut%0d halted", g), 256'(halted_v[g]), 256'(0));
            chk($sformatf("rst dut%0d timeout", g), 256'(to_v[g]), 256'(0));
            chk($sformatf("rst dut%0d ready", g), 256'(ready_v[g]), 256'(1));
            chk($sformatf("rst dut%0d pc", g), 256'(pc_v[g]), 256'(0));
            chk($sformatf("rst dut%0d count", g), 256'(cc_v[g]), 256'(0));
            chk($sformatf("rst dut%0d regs", g), regs_v[g], 256'(0));
        end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) wr(i, '0);

        // r0<-5, r1<-7, r2<-r0+r1 with HALT
        wr(0, dst(ins(32'd5, 0, 0, 0), 0, 15));
        wr(1, dst(ins(32'd7, 0, 0, 0), 1, 15));
        wr(2, dst(opr(ins(32'd0, 1, 0, 0), 0, 0, 1), 2, 9));
        go();
        wait_done();
        chk("basic r2", 256'(reg_of(0, 2)), 256'(12));
        chk("basic pc", 256'(pc_v[0]), 256'(2));
        chk("basic count", 256'(cc_v[0]), 256'(3));

        // countdown r0=3 by r1=-1, loop back to word 2 while r0!=0
        wr(0, dst(ins(32'd3, 0, 0, 0), 0, 15));
        wr(1, dst(ins(32'hFFFF_FFFF, 0, 0, 0), 1, 15));
        wr(2, dst(opr(ins(32'd0, 0, 0, 0), 0, 0, 1), 0, 9));
        wr(3, ins(32'd2, 0, 1, 15));
        wr(4, ins(32'd0, 1, 0, 0));
        go();
        wait_done();
        chk("countdown r0", 256'(reg_of(1, 0)), 256'(0));
        chk("countdown count", 256'(cc_v[1]), 256'(9));
        chk("countdown short watchdog", 256'(to_v[0]), 256'(1));

        // max (signed vs unsigned) and equality
        wr(0, dst(ins(32'hFFFF_FFFE, 0, 0, 0), 0, 15));
        wr(1, dst(ins(32'd3, 0, 0, 0), 1, 15));
        w = opr(opr(ins(32'd0, 1, 0, 0), 2, 0, 1), 4, 0, 0);
        wr(2, dst(dst(w, 2, 11), 3, 13));
        go();
        wait_done();
        chk("max signed", 256'(reg_of(0, 2)), 256'(3));
        chk("max unsigned", 256'(reg_of(1, 2)), 256'(32'hFFFF_FFFE));
        chk("equal dut0", 256'(reg_of(0, 3)), 256'(32'hFFFF_FFFF));
        chk("equal dut1", 256'(reg_of(1, 3)), 256'(32'hFFFF_FFFF));

        // watchdog: jump to self forever
        wr(0, ins(32'd0, 0, 0, 15));
        go();
        wait_done();
        chk("watchdog timeout", 256'(to_v[0]), 256'(1));
        chk("watchdog count", 256'(cc_v[0]), 256'(8));
        go();
        chk("restart clears timeout", 256'(to_v), 256'(0));
        chk("restart busy", 256'(busy_v), 256'(3));
        wait_done();

        // reset two instructions into a run, then rerun the retained program
        wr(0, dst(ins(32'd5, 0, 0, 0), 0, 15));
        wr(1, dst(ins(32'd7, 0, 0, 0), 1, 15));
        wr(2, dst(opr(ins(32'd0, 1, 0, 0), 0, 0, 1), 2, 9));
        go();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrun r1 before reset", 256'(reg_of(0, 1)), 256'(7));
        rst = 1'b1;
        #1;
        chk("midrun busy", 256'(busy_v), 256'(0));
        chk("midrun pc", 256'({pc_v[1], pc_v[0]}), 256'(0));
        chk("midrun regs", regs_v[0] | regs_v[1], 256'(0));
        q0.delete();
        q1.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        go();
        wait_done();
        chk("rerun r2", 256'(reg_of(1, 2)), 256'(12));

        // writes while busy are refused
        wr(0, ins(32'd0, 0, 0, 15));
        go();
        wr_valid = 1'b1;
        wr_addr  = 4'd0;
        wr_data  = ins(32'd0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("ready low in run", 256'(ready_v), 256'(0));
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        wait_done();

        // write and start together: the new word runs first
        w = dst(ins(32'h0000_A5A5, 1, 0, 0), 5, 15);
        wr_valid = 1'b1;
        wr_addr  = 4'd0;
        wr_data  = w;
        img[0]   = w;
        expect_run();
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        wr_valid = 1'b0;
        wait_done();
        chk("write+start r5", 256'(reg_of(0, 5)), 256'(32'hA5A5));
        chk("write+start count", 256'(cc_v[0]), 256'(1));

        // random programs
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 16; i++) begin
                w = IW'({$urandom(), $urandom(), $urandom(), $urandom()});
                w[32] = ($urandom_range(0, 3) == 0);
                wr(i, w);
            end
            go();
            wait_done();
        end

        chk("scoreboard drained", 256'(q0.size() + q1.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
